sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single SDRAM controller request port between the fx68k CPU bus and the ESP32 SPI loader port (spi_ram_btn). It assembles SPI byte writes into 16-bit words and holds CPU cycles off with DTACKn until the memory completes. A hold input gives the loader exclusive ownership. A watchdog aborts transactions the controller never acknowledges.

## Interface
- `c_timeout`, default 255: cycles from `mem_req` to forced abort. Range 4..4095.
- `c_spi_first`, default 1: when both ports request in the same cycle with no history, SPI wins.

Ports:
- `clk` in 1: system clock (clk_cpu domain, 25 MHz).
- `reset` in 1: synchronous, active-high.
- `cpu_sel` in 1: CPU address decodes to SDRAM.
- `cpu_as_n` in 1: CPU address strobe.
- `cpu_rw` in 1: CPU direction; 1 = read.
- `cpu_uds_n` in 1: CPU upper data strobe.
- `cpu_lds_n` in 1: CPU lower data strobe.
- `cpu_a` in 23: CPU word address [23:1].
- `cpu_dout` in 16: CPU write data.
- `cpu_din` out 16: read data to CPU.
- `cpu_dtack_n` out 1: transfer acknowledge.
- `cpu_hold` in 1: loader owns memory; CPU requests are not granted.
- `spi_wr` in 1: SPI write strobe. Level; one transfer per rising edge.
- `spi_rd` in 1: SPI read strobe. Level; one transfer per rising edge.
- `spi_addr` in 24: SPI byte address.
- `spi_data_in` in 8: SPI write byte.
- `spi_data_out` out 8: SPI read byte.
- `mem_req` out 1: request to the controller. Held until `mem_ack` or abort.
- `mem_we` out 1: write.
- `mem_addr` out 23: word address.
- `mem_be` out 2: byte enables {upper, lower}.
- `mem_din` out 16: write data.
- `mem_dout` in 16: read data. Valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle completion pulse.
- `err_timeout` out 1: sticky; set on a watchdog abort.
- `err_overrun` out 1: sticky; set when an SPI edge is lost.

## Operation
- SPI edge detect: one register each on `spi_wr` and `spi_rd`. A rising edge is an SPI event.
- Even-address write event: latch `spi_data_in` into `byte_hi`. No memory cycle.
- Odd-address write event: set `spi_pend`, type write, data {`byte_hi`, `spi_data_in`}, `mem_be`=11.
- Read event: set `spi_pend`, type read, `mem_be`=11. Address fields are captured at the event.
- If an event arrives while `spi_pend` is already set, the new event is dropped and `err_overrun` is set.
- CPU request: `cpu_sel` & !`cpu_as_n` & (!`cpu_uds_n` | !`cpu_lds_n`) & `cpu_phase`==IDLE. Sampled by a register.
- `mem_be` for CPU = {!`cpu_uds_n`, !`cpu_lds_n`}.
- FSM states:
  - IDLE → SPI_BUSY if the SPI port wins the grant.
  - IDLE → CPU_BUSY if the CPU port wins the grant.
  - SPI_BUSY → IDLE on `mem_ack` or abort.
  - CPU_BUSY → CPU_DONE on `mem_ack` or abort.
  - CPU_DONE → IDLE when `cpu_as_n`=1.
- Grant rule:
  - Only one port pending: that port wins.
  - Both pending: the port not granted last wins.
  - `last` resets to CPU when `c_spi_first`=1.
  - `cpu_hold`=1 blocks CPU grants only. A CPU cycle already in progress completes.
- Read data:
  - SPI read: `mem_dout` is latched. `spi_data_out` = `spi_addr[0]` ? [7:0] : [15:8].
  - CPU read: `mem_dout` is latched into `cpu_din`.
- `cpu_dtack_n` is 0 in CPU_DONE only. It rises in the cycle after `cpu_as_n` goes high.
- Watchdog:
  - Counter loads 0 on grant and increments while `mem_req`=1.
  - At `c_timeout`: drop `mem_req`, set `err_timeout`.
  - Abort on a read returns 16'hFFFF.
  - Abort on CPU still goes to CPU_DONE, so the CPU never hangs.
- Reset values:
  - Outputs: `mem_req`=0, `mem_we`=0, `mem_be`=00, `mem_addr`=0, `mem_din`=0, `cpu_din`=0, `cpu_dtack_n`=1, `spi_data_out`=0, `err_*`=0.
  - Internal: FSM IDLE, `spi_pend`=0, `byte_hi`=0.
  - Reset mid-transaction drops `mem_req` in the next cycle; the pending request is discarded.

## Timing
- Event to `mem_req`:
  - SPI event to `mem_req`: 2 cycles when idle (edge register + grant).
  - CPU strobe to `mem_req`: 2 cycles.
- `mem_ack` to outputs:
  - SPI read: `mem_ack` to `spi_data_out` valid is 1 cycle.
  - CPU: `mem_ack` to `cpu_dtack_n`=0 with `cpu_din` valid is 1 cycle.
- `mem_*` outputs are registered and stable while `mem_req`=1.
- `mem_ack` arriving while not busy is ignored.
- Back-to-back grants: one IDLE cycle minimum between transactions.
- Simultaneous SPI event and `mem_ack` of a prior SPI cycle: the event is accepted, no overrun.

## Test plan
- SPI writes: AB to byte address 0x000010, then CD to 0x000011 → exactly one `mem_req`, `mem_we`=1, `mem_addr`=0x000008, `mem_din`=ABCD, `mem_be`=11.
- SPI read at 0x000011 with `mem_dout`=1234, ack after 5 cycles → `spi_data_out`=34. Repeat at 0x000010 → 12.
- CPU word read at `cpu_a`=0x000100 (uds and lds low), `mem_dout`=BEEF, ack after 3 cycles → `cpu_din`=BEEF, `cpu_dtack_n`=0 until AS high, then 1 the next cycle.
- CPU and SPI requests in the same cycle after reset with `c_spi_first`=1 → SPI granted first, CPU second. Repeat with both pending again → CPU first.
- `cpu_hold`=1 with a CPU request pending and three SPI reads → all three SPI reads granted, no CPU grant. Release hold → CPU granted, `cpu_dtack_n` asserts.
- Controller never acks, `c_timeout`=8 → `mem_req` drops after 8 cycles, `err_timeout`=1, `cpu_din`=FFFF with DTACK. A second SPI read edge while the first is pending → `err_overrun`=1.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM controller request port between the 68k CPU bus and the
// SPI loader; packs SPI byte writes into words and guards cycles with a watchdog.
module sdram_port_arbiter #(
  parameter int unsigned c_timeout   = 255,
  parameter bit          c_spi_first = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic        cpu_as_n,
  input  logic        cpu_rw,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic [22:0] cpu_a,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_dtack_n,
  input  logic        cpu_hold,
  input  logic        spi_wr,
  input  logic        spi_rd,
  input  logic [23:0] spi_addr,
  input  logic [7:0]  spi_data_in,
  output logic [7:0]  spi_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_ack,
  output logic        err_timeout,
  output logic        err_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_SPI_BUSY, ST_CPU_BUSY, ST_CPU_DONE} state_t;
  typedef enum logic {PORT_CPU, PORT_SPI} port_t;

  localparam logic [11:0] LP_WD_LAST = 12'(c_timeout - 1);

  state_t      r_state;
  port_t       r_last;
  logic [11:0] r_wd;
  logic        r_spi_wr_d, r_spi_rd_d;
  logic        r_spi_pend, r_spi_we, r_spi_lsb;
  logic [22:0] r_spi_addr;
  logic [15:0] r_spi_wdata;
  logic [7:0]  r_byte_hi;
  logic        r_cpu_pend;

  logic w_wr_ev, w_rd_ev, w_busy, w_abort, w_end, w_spi_free;
  logic w_cpu_rq, w_cpu_ok, w_grant_spi, w_grant_cpu;

  always_comb begin
    w_wr_ev     = spi_wr & ~r_spi_wr_d;
    w_rd_ev     = spi_rd & ~r_spi_rd_d;
    w_busy      = (r_state == ST_SPI_BUSY) || (r_state == ST_CPU_BUSY);
    w_abort     = w_busy && !mem_ack && (r_wd == LP_WD_LAST);
    w_end       = w_busy && (mem_ack || w_abort);
    // The SPI slot frees in the completion cycle, so an edge landing on the ack is kept.
    w_spi_free  = !r_spi_pend || ((r_state == ST_SPI_BUSY) && w_end);
    w_cpu_rq    = cpu_sel && !cpu_as_n && (!cpu_uds_n || !cpu_lds_n) && !r_cpu_pend &&
                  (r_state != ST_CPU_BUSY) && (r_state != ST_CPU_DONE);
    w_cpu_ok    = r_cpu_pend && !cpu_hold;
    w_grant_spi = (r_state == ST_IDLE) && r_spi_pend && (!w_cpu_ok || (r_last == PORT_CPU));
    w_grant_cpu = (r_state == ST_IDLE) && w_cpu_ok && !w_grant_spi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last       <= c_spi_first ? PORT_CPU : PORT_SPI;
      r_wd         <= '0;
      r_spi_wr_d   <= 1'b0;
      r_spi_rd_d   <= 1'b0;
      r_spi_pend   <= 1'b0;
      r_spi_we     <= 1'b0;
      r_spi_lsb    <= 1'b0;
      r_spi_addr   <= '0;
      r_spi_wdata  <= '0;
      r_byte_hi    <= '0;
      r_cpu_pend   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_din      <= '0;
      cpu_din      <= '0;
      cpu_dtack_n  <= 1'b1;
      spi_data_out <= '0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      r_spi_wr_d <= spi_wr;
      r_spi_rd_d <= spi_rd;
      if (w_cpu_rq) r_cpu_pend <= 1'b1;
      if (w_busy) r_wd <= r_wd + 12'd1;

      if ((r_state == ST_SPI_BUSY) && w_end) r_spi_pend <= 1'b0;
      if (w_wr_ev || w_rd_ev) begin
        if (!w_spi_free) begin
          err_overrun <= 1'b1;
        end else if (w_wr_ev) begin
          if (w_rd_ev) err_overrun <= 1'b1;
          if (!spi_addr[0]) begin
            r_byte_hi <= spi_data_in;
          end else begin
            r_spi_pend  <= 1'b1;
            r_spi_we    <= 1'b1;
            r_spi_addr  <= spi_addr[23:1];
            r_spi_wdata <= {r_byte_hi, spi_data_in};
          end
        end else begin
          r_spi_pend <= 1'b1;
          r_spi_we   <= 1'b0;
          r_spi_addr <= spi_addr[23:1];
          r_spi_lsb  <= spi_addr[0];
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant_spi) begin
            mem_req  <= 1'b1;
            mem_we   <= r_spi_we;
            mem_addr <= r_spi_addr;
            mem_be   <= 2'b11;
            mem_din  <= r_spi_wdata;
            r_wd     <= '0;
            r_last   <= PORT_SPI;
            r_state  <= ST_SPI_BUSY;
          end else if (w_grant_cpu) begin
            mem_req    <= 1'b1;
            mem_we     <= !cpu_rw;
            mem_addr   <= cpu_a;
            mem_be     <= {!cpu_uds_n, !cpu_lds_n};
            mem_din    <= cpu_dout;
            r_wd       <= '0;
            r_last     <= PORT_CPU;
            r_cpu_pend <= 1'b0;
            r_state    <= ST_CPU_BUSY;
          end
        end
        ST_SPI_BUSY: begin
          if (w_end) begin
            mem_req <= 1'b0;
            r_state <= ST_IDLE;
            if (w_abort) err_timeout <= 1'b1;
            if (!mem_we) begin
              if (!mem_ack) spi_data_out <= 8'hFF;
              else          spi_data_out <= r_spi_lsb ? mem_dout[7:0] : mem_dout[15:8];
            end
          end
        end
        ST_CPU_BUSY: begin
          if (w_end) begin
            mem_req     <= 1'b0;
            cpu_dtack_n <= 1'b0;
            r_state     <= ST_CPU_DONE;
            if (w_abort) err_timeout <= 1'b1;
            if (!mem_we) cpu_din <= mem_ack ? mem_dout : 16'hFFFF;
          end
        end
        ST_CPU_DONE: begin
          if (cpu_as_n) begin
            cpu_dtack_n <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with hand-computed expectations.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel, cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n;
  logic [22:0] cpu_a;
  logic [15:0] cpu_dout, cpu_din;
  logic        cpu_dtack_n, cpu_hold;
  logic        spi_wr, spi_rd;
  logic [23:0] spi_addr;
  logic [7:0]  spi_data_in, spi_data_out;
  logic        mem_req, mem_we, mem_ack;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_din, mem_dout;
  logic        err_timeout, err_overrun;

  int n_chk = 0;
  int n_err = 0;
  int n_req = 0;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.c_timeout(8), .c_spi_first(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel(cpu_sel), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n),
    .cpu_hold(cpu_hold), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_addr(spi_addr), .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always @(negedge clk) begin
    if (mem_req && !req_q) n_req++;
    req_q = mem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !mem_req; i++) tick();
    check(tag, mem_req, 1);
  endtask

  task automatic ack(input logic [15:0] d);
    mem_ack = 1'b1; mem_dout = d;
    tick();
    mem_ack = 1'b0; mem_dout = '0;
  endtask

  task automatic spi_pulse(input logic wr, input logic [23:0] a, input logic [7:0] d);
    spi_addr = a; spi_data_in = d;
    if (wr) spi_wr = 1'b1; else spi_rd = 1'b1;
    tick();
    spi_wr = 1'b0; spi_rd = 1'b0;
  endtask

  task automatic cpu_start(input logic rw, input logic [22:0] a, input logic uds_n,
                           input logic lds_n, input logic [15:0] d);
    cpu_sel = 1'b1; cpu_as_n = 1'b0; cpu_rw = rw; cpu_a = a;
    cpu_uds_n = uds_n; cpu_lds_n = lds_n; cpu_dout = d;
  endtask

  task automatic cpu_end();
    cpu_sel = 1'b0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int n0, n;
    reset = 1'b1; cpu_sel = 1'b0; cpu_as_n = 1'b1; cpu_rw = 1'b1;
    cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_a = '0; cpu_dout = '0; cpu_hold = 1'b0;
    spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = '0; spi_data_in = '0;
    mem_ack = 1'b0; mem_dout = '0;
    do_reset();

    check("rst_req", mem_req, 0);
    check("rst_dtack", cpu_dtack_n, 1);
    check("rst_be_addr", {mem_be, mem_addr, mem_we}, 0);
    check("rst_din", {cpu_din, mem_din, spi_data_out}, 0);
    check("rst_err", {err_timeout, err_overrun}, 0);

    // SPI byte pair assembles into one word write
    n0 = n_req;
    spi_pulse(1'b1, 24'h000010, 8'hAB);
    tick(); tick();
    check("spi_even_noreq", mem_req, 0);
    spi_addr = 24'h000011; spi_data_in = 8'hCD; spi_wr = 1'b1;
    tick();
    spi_wr = 1'b0;
    check("spi_lat1", mem_req, 0);
    tick();
    check("spi_lat2", mem_req, 1);
    check("spi_wr_we", mem_we, 1);
    check("spi_wr_addr", mem_addr, 23'h000008);
    check("spi_wr_din", mem_din, 16'hABCD);
    check("spi_wr_be", mem_be, 2'b11);
    tick(); tick();
    ack(16'h0000);
    check("spi_wr_done", mem_req, 0);
    check("spi_wr_count", n_req - n0, 1);

    // SPI reads pick the byte lane from the address LSB
    spi_pulse(1'b0, 24'h000011, 8'h00);
    wait_req("spi_rd1_req");
    check("spi_rd1_we", mem_we, 0);
    for (int i = 0; i < 4; i++) tick();
    ack(16'h1234);
    check("spi_rd_odd", spi_data_out, 8'h34);
    spi_pulse(1'b0, 24'h000010, 8'h00);
    wait_req("spi_rd2_req");
    for (int i = 0; i < 4; i++) tick();
    ack(16'h1234);
    check("spi_rd_even", spi_data_out, 8'h12);

    // CPU word read
    cpu_start(1'b1, 23'h000100, 1'b0, 1'b0, 16'h0000);
    tick();
    check("cpu_lat1", mem_req, 0);
    tick();
    check("cpu_lat2", mem_req, 1);
    check("cpu_rd_addr", mem_addr, 23'h000100);
    check("cpu_rd_be_we", {mem_be, mem_we}, 3'b110);
    tick(); tick();
    ack(16'hBEEF);
    check("cpu_dtack_lo", cpu_dtack_n, 0);
    check("cpu_din", cpu_din, 16'hBEEF);
    tick();
    check("cpu_dtack_hold", cpu_dtack_n, 0);
    cpu_end();
    check("cpu_dtack_hi", cpu_dtack_n, 1);

    // Simultaneous requests after reset, then alternation
    do_reset();
    cpu_start(1'b1, 23'h000200, 1'b0, 1'b0, 16'h0000);
    spi_addr = 24'h000600; spi_rd = 1'b1;
    tick();
    spi_rd = 1'b0;
    tick();
    check("arb_first_spi", {mem_req, mem_addr}, {1'b1, 23'h000300});
    tick();
    spi_addr = 24'h000601; spi_rd = 1'b1;
    ack(16'h0000);
    spi_rd = 1'b0;
    check("arb_ack_edge_noovr", err_overrun, 0);
    tick();
    check("arb_second_cpu", {mem_req, mem_addr}, {1'b1, 23'h000200});
    ack(16'h5555);
    check("arb_cpu_dtack", cpu_dtack_n, 0);
    cpu_end();
    tick();
    check("arb_third_spi", {mem_req, mem_addr}, {1'b1, 23'h000300});
    ack(16'hA1B2);
    check("arb_third_data", spi_data_out, 8'hB2);

    // Hold keeps the CPU off while the loader runs
    cpu_hold = 1'b1;
    cpu_start(1'b0, 23'h000040, 1'b0, 1'b1, 16'h7700);
    tick(); tick();
    n0 = n_req;
    for (int k = 0; k < 3; k++) begin
      spi_pulse(1'b0, 24'h000100 + 24'(2 * k), 8'h00);
      wait_req("hold_spi_req");
      check("hold_spi_addr", mem_addr, 23'h000080 + 23'(k));
      tick();
      ack(16'h0000);
    end
    tick(); tick();
    check("hold_no_cpu", mem_req, 0);
    check("hold_count", n_req - n0, 3);
    cpu_hold = 1'b0;
    tick();
    check("hold_cpu_req", mem_req, 1);
    check("hold_cpu_wr", {mem_we, mem_be, mem_addr, mem_din}, {1'b1, 2'b10, 23'h000040, 16'h7700});
    ack(16'h0000);
    check("hold_cpu_dtack", cpu_dtack_n, 0);
    cpu_end();

    // Watchdog abort on a CPU read
    cpu_start(1'b1, 23'h000123, 1'b0, 1'b0, 16'h0000);
    wait_req("wd_req");
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("wd_len", n, 8);
    check("wd_err", err_timeout, 1);
    check("wd_din", cpu_din, 16'hFFFF);
    check("wd_dtack", cpu_dtack_n, 0);
    cpu_end();
    check("wd_dtack_rel", cpu_dtack_n, 1);

    // Overrun on a second SPI read edge, then its abort
    spi_pulse(1'b0, 24'h000020, 8'h00);
    wait_req("ovr_req");
    check("ovr_pre", err_overrun, 0);
    spi_pulse(1'b0, 24'h000022, 8'h00);
    check("ovr_set", err_overrun, 1);
    for (int i = 0; i < 40 && mem_req; i++) tick();
    check("ovr_abort_done", mem_req, 0);
    check("ovr_abort_data", spi_data_out, 8'hFF);

    // Reset mid-transaction discards the request
    spi_pulse(1'b0, 24'h000030, 8'h00);
    wait_req("rst_mid_req");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_drop", mem_req, 0);
    tick(); tick(); tick();
    check("rst_mid_stay", {mem_req, err_timeout, err_overrun}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
